// File: rtl/sram_like_pkg.sv
// Shared encodings and helpers for the sram-like arbiter: access sizes and
// byte-enable generation from size plus the low address bits.
package sram_like_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~addr_lo[0];
            SZ_WORD: ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Misaligned or reserved-size writes yield no lanes, so the write is dropped.
    function automatic logic [3:0] gen_wen(input logic [1:0] size, input logic [1:0] addr_lo,
                                           input logic wr);
        logic [3:0] wen;
        wen = 4'b0000;
        if (wr && is_aligned(size, addr_lo)) begin
            case (size)
                SZ_BYTE: wen = 4'b0001 << addr_lo;
                SZ_HALF: wen = 4'b0011 << addr_lo;
                SZ_WORD: wen = 4'b1111;
                default: wen = 4'b0000;
            endcase
        end
        return wen;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, and the pointer moves one
// past the granted master whenever a grant is made.
module rr_arbiter #(
    parameter int N    = 2,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            grant_valid
);

    logic [ID_W-1:0] r_ptr;

    // Walk offsets from highest to lowest so the closest requester to r_ptr wins.
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(r_ptr) + i) % N]) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'((int'(r_ptr) + i) % N);
            end
        end
        if (grant_valid) begin
            grant = N'(1) << grant_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (grant_valid) begin
            r_ptr <= (int'(grant_id) == N - 1) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// N-master to one-RAM arbiter: grant mux, byte-enable generation and a fixed
// latency response pipe that returns data_ok to masters in grant order.
module sram_like_arbiter
    import sram_like_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int RD_LATENCY  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS-1:0]        m_wr,
    input  logic [2*NUM_MASTERS-1:0]      m_size,
    input  logic [ADDR_W*NUM_MASTERS-1:0] m_addr,
    input  logic [32*NUM_MASTERS-1:0]     m_wdata,
    output logic [NUM_MASTERS-1:0]        m_addr_ok,
    output logic [NUM_MASTERS-1:0]        m_data_ok,
    output logic [31:0]                   m_rdata,
    output logic                          mem_en,
    output logic [3:0]                    mem_wen,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [31:0]                   mem_wdata,
    input  logic [31:0]                   mem_rdata
);

    localparam int MID_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] w_grant;
    logic [MID_W-1:0]       w_gid;
    logic                   w_arb_vld;
    logic                   w_gnt_vld;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic                   w_resp;

    logic                   r_vld [RD_LATENCY];
    logic [MID_W-1:0]       r_mid [RD_LATENCY];

    rr_arbiter #(.N(NUM_MASTERS), .ID_W(MID_W)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (m_req),
        .grant       (w_grant),
        .grant_id    (w_gid),
        .grant_valid (w_arb_vld)
    );

    assign w_gnt_vld  = w_arb_vld & ~rst;
    assign w_sel_addr = m_addr[ADDR_W*w_gid +: ADDR_W];

    always_comb begin
        m_addr_ok = '0;
        mem_en    = 1'b0;
        mem_wen   = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_gnt_vld) begin
            m_addr_ok = w_grant;
            mem_en    = 1'b1;
            mem_addr  = {w_sel_addr[ADDR_W-1:2], 2'b00};
            mem_wdata = m_wdata[32*w_gid +: 32];
            mem_wen   = gen_wen(m_size[2*w_gid +: 2], w_sel_addr[1:0], m_wr[w_gid]);
        end
    end

    // Every grant, read or write, occupies one slot so responses stay in order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_vld[i] <= 1'b0;
                r_mid[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_gnt_vld;
            r_mid[0] <= w_gid;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_mid[i] <= r_mid[i-1];
            end
        end
    end

    assign w_resp    = r_vld[RD_LATENCY-1] & ~rst;
    assign m_data_ok = w_resp ? (NUM_MASTERS'(1) << r_mid[RD_LATENCY-1]) : '0;
    assign m_rdata   = w_resp ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: three configurations (N2/L1, N3/L3, N4/L2),
// each with its own RAM model and expected-response queue.
module tb_sram_like_arbiter;
    import sram_like_pkg::*;

    localparam int W = 52;  // {due_cycle[15:0], mid[2:0], chk_rdata, rdata[31:0]}

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        rst = 3'b111;
    logic [2:0][7:0]   req = '0;
    logic [2:0][7:0]   wr = '0;
    logic [2:0][15:0]  size = '0;
    logic [2:0][255:0] addr = '0;
    logic [2:0][255:0] wdata = '0;

    logic [2:0][7:0]   addr_ok;
    logic [2:0][7:0]   data_ok;
    logic [2:0][31:0]  rdata;
    logic [2:0][31:0]  mem_addr_o;
    logic [2:0][31:0]  mem_wdata_o;
    logic [2:0]        mem_en_o;
    logic [2:0][3:0]   mem_wen_o;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    logic [W-1:0] exp_q2[$];

    logic [1:0] t_sz  [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd2};
    logic [1:0] t_a   [8] = '{2'd0, 2'd2, 2'd2, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0};
    logic       t_wr  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] t_wen [8] = '{4'b0001, 4'b0100, 4'b1100, 4'b0011,
                              4'b1111, 4'b0000, 4'b0000, 4'b0000};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
    endfunction

    function automatic logic [31:0] ram_init(input int k, input int i);
        if (k == 0 && i == 64) return 32'hDEADBEEF;
        return {8'hC0 + 8'(k), 8'h11, 8'(i), 8'h5A};
    endfunction

    // ---------------- DUT instances with behavioural RAMs ----------------
    for (genvar k = 0; k < 3; k++) begin : g_cfg
        localparam int NM  = (k == 0) ? 2 : ((k == 1) ? 3 : 4);
        localparam int LAT = (k == 0) ? 1 : ((k == 1) ? 3 : 2);

        logic [NM-1:0] w_aok, w_dok;
        logic [31:0]   w_rd, w_maddr, w_mwd, w_mrd;
        logic          w_men;
        logic [3:0]    w_mwen;
        logic [31:0]   ram   [256];
        logic [31:0]   rpipe [LAT];

        sram_like_arbiter #(.NUM_MASTERS(NM), .ADDR_W(32), .RD_LATENCY(LAT)) u_dut (
            .clk       (clk),
            .rst       (rst[k]),
            .m_req     (req[k][NM-1:0]),
            .m_wr      (wr[k][NM-1:0]),
            .m_size    (size[k][2*NM-1:0]),
            .m_addr    (addr[k][32*NM-1:0]),
            .m_wdata   (wdata[k][32*NM-1:0]),
            .m_addr_ok (w_aok),
            .m_data_ok (w_dok),
            .m_rdata   (w_rd),
            .mem_en    (w_men),
            .mem_wen   (w_mwen),
            .mem_addr  (w_maddr),
            .mem_wdata (w_mwd),
            .mem_rdata (w_mrd)
        );

        assign addr_ok[k]     = 8'(w_aok);
        assign data_ok[k]     = 8'(w_dok);
        assign rdata[k]       = w_rd;
        assign mem_addr_o[k]  = w_maddr;
        assign mem_wdata_o[k] = w_mwd;
        assign mem_en_o[k]    = w_men;
        assign mem_wen_o[k]   = w_mwen;
        assign w_mrd          = rpipe[LAT-1];

        always @(posedge clk) begin
            if (rst[k]) begin
                for (int i = 0; i < 256; i++) ram[i] <= ram_init(k, i);
            end else if (w_men) begin
                for (int b = 0; b < 4; b++)
                    if (w_mwen[b]) ram[w_maddr[9:2]][8*b +: 8] <= w_mwd[8*b +: 8];
            end
            rpipe[0] <= w_men ? ram[w_maddr[9:2]] : 32'h0;
            for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input int m, input logic w, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] d);
        req[k][m]          = 1'b1;
        wr[k][m]           = w;
        size[k][2*m +: 2]  = sz;
        addr[k][32*m +: 32]  = a;
        wdata[k][32*m +: 32] = d;
    endtask

    task automatic push_exp(input int k, input int mid, input logic chk, input logic [31:0] d);
        logic [W-1:0] e;
        e = {16'(cyc + lat_of(k)), 3'(mid), chk, d};
        case (k)
            0:       exp_q0.push_back(e);
            1:       exp_q1.push_back(e);
            default: exp_q2.push_back(e);
        endcase
    endtask

    // Waits to the falling edge of the current cycle and checks the grant.
    task automatic expect_grant(input int k, input int m, input logic push, input logic chk,
                                input logic [31:0] d, input string name);
        @(negedge clk);
        check($sformatf("%s_addr_ok", name), addr_ok[k], 64'(8'(1) << m));
        check($sformatf("%s_mem_en", name), mem_en_o[k], 1);
        if (push) push_exp(k, m, chk, d);
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic mon(input int k);
        logic [W-1:0] e;
        logic         have;
        e = '0;
        case (k)
            0:       have = (exp_q0.size() > 0);
            1:       have = (exp_q1.size() > 0);
            default: have = (exp_q2.size() > 0);
        endcase
        if (have) begin
            case (k)
                0:       e = exp_q0[0];
                1:       e = exp_q1[0];
                default: e = exp_q2[0];
            endcase
        end
        if (data_ok[k] != 8'h0 || (have && 32'(e[51:36]) <= cyc)) begin
            if (!have) begin
                checks++;
                errors++;
                $display("FAIL unexpected_data_ok cfg%0d actual=%0h expected=0", k, data_ok[k]);
            end else begin
                case (k)
                    0:       void'(exp_q0.pop_front());
                    1:       void'(exp_q1.pop_front());
                    default: void'(exp_q2.pop_front());
                endcase
                check($sformatf("cfg%0d_resp_cycle", k), 64'(cyc), 64'(e[51:36]));
                check($sformatf("cfg%0d_resp_mid", k), data_ok[k], 64'(8'(1) << e[35:33]));
                if (e[32]) check($sformatf("cfg%0d_resp_rdata", k), rdata[k], e[31:0]);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) mon(k);
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [31:0] w;

        // Reset with every master requesting: nothing may be granted.
        req = '1;
        tick();
        tick();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_addr_ok_cfg%0d", k), addr_ok[k], 0);
            check($sformatf("rst_data_ok_cfg%0d", k), data_ok[k], 0);
            check($sformatf("rst_mem_en_cfg%0d", k), mem_en_o[k], 0);
            check($sformatf("rst_mem_wen_cfg%0d", k), mem_wen_o[k], 0);
            check($sformatf("rst_mem_addr_cfg%0d", k), mem_addr_o[k], 0);
        end
        tick();
        rst = 3'b000;
        req = '0;

        // cfg0: both masters request every cycle -> 0,1,0,1.
        set_req(0, 0, 1'b0, SZ_WORD, 32'h10, 32'h0);
        set_req(0, 1, 1'b0, SZ_WORD, 32'h20, 32'h0);
        for (int i = 0; i < 4; i++) begin
            expect_grant(0, i % 2, 1'b1, 1'b1, ram_init(0, (i % 2 == 1) ? 8 : 4),
                         $sformatf("alt%0d", i));
            tick();
        end
        req[0] = '0;

        // cfg0: single read of 0x100.
        set_req(0, 0, 1'b0, SZ_WORD, 32'h100, 32'h0);
        expect_grant(0, 0, 1'b1, 1'b1, 32'hDEADBEEF, "rd100");
        check("rd100_mem_addr", mem_addr_o[0], 32'h100);
        check("rd100_mem_wen", mem_wen_o[0], 4'b0000);
        tick();
        req[0] = '0;
        tick();

        // cfg0: byte write to 0x203, then misaligned half write to 0x201.
        set_req(0, 1, 1'b1, SZ_BYTE, 32'h203, 32'hAB000000);
        expect_grant(0, 1, 1'b1, 1'b0, 32'h0, "wb203");
        check("wb203_mem_wen", mem_wen_o[0], 4'b1000);
        check("wb203_mem_addr", mem_addr_o[0], 32'h200);
        check("wb203_mem_wdata", mem_wdata_o[0], 32'hAB000000);
        tick();
        set_req(0, 1, 1'b1, SZ_HALF, 32'h201, 32'h12345678);
        expect_grant(0, 1, 1'b1, 1'b0, 32'h0, "wh201");
        check("wh201_mem_wen", mem_wen_o[0], 4'b0000);
        tick();
        req[0] = '0;

        // cfg0: byte-enable table.
        for (int i = 0; i < 8; i++) begin
            set_req(0, 0, t_wr[i], t_sz[i], 32'h300 + 32'(t_a[i]), 32'h55555555);
            expect_grant(0, 0, 1'b1, 1'b0, 32'h0, $sformatf("wen%0d", i));
            check($sformatf("wen%0d_mem_wen", i), mem_wen_o[0], t_wen[i]);
            check($sformatf("wen%0d_mem_addr", i), mem_addr_o[0], 32'h300);
            tick();
        end
        req[0] = '0;

        // cfg0: read back what the writes left behind.
        w = ram_init(0, 128);
        w[31:24] = 8'hAB;
        set_req(0, 0, 1'b0, SZ_WORD, 32'h200, 32'h0);
        expect_grant(0, 0, 1'b1, 1'b1, w, "rb200");
        tick();
        set_req(0, 0, 1'b0, SZ_WORD, 32'h300, 32'h0);
        expect_grant(0, 0, 1'b1, 1'b1, 32'h55555555, "rb300");
        tick();
        req[0] = '0;

        // cfg1 (LAT 3): reads from m2, m0, m1 on consecutive cycles.
        set_req(1, 2, 1'b0, SZ_WORD, 32'h40, 32'h0);
        expect_grant(1, 2, 1'b1, 1'b1, ram_init(1, 16), "b2b_m2");
        tick();
        req[1] = '0;
        set_req(1, 0, 1'b0, SZ_WORD, 32'h44, 32'h0);
        expect_grant(1, 0, 1'b1, 1'b1, ram_init(1, 17), "b2b_m0");
        tick();
        req[1] = '0;
        set_req(1, 1, 1'b0, SZ_WORD, 32'h48, 32'h0);
        expect_grant(1, 1, 1'b1, 1'b1, ram_init(1, 18), "b2b_m1");
        tick();
        req[1] = '0;
        // All three now request; pointer sits at 2.
        for (int m = 0; m < 3; m++) set_req(1, m, 1'b0, SZ_WORD, 32'h50 + 32'(4 * m), 32'h0);
        for (int i = 0; i < 3; i++) begin
            expect_grant(1, (2 + i) % 3, 1'b1, 1'b1, ram_init(1, 20 + (2 + i) % 3),
                         $sformatf("rr3_%0d", i));
            tick();
        end
        req[1] = '0;

        // cfg2 (N4): only m3 requests for three cycles.
        set_req(2, 3, 1'b0, SZ_WORD, 32'h0C, 32'h0);
        for (int i = 0; i < 3; i++) begin
            expect_grant(2, 3, 1'b1, 1'b1, ram_init(2, 3), $sformatf("m3only%0d", i));
            tick();
        end
        req[2] = '0;
        tick();

        // cfg2 (LAT 2): two grants, then reset; their responses must vanish.
        set_req(2, 0, 1'b0, SZ_WORD, 32'h0, 32'h0);
        expect_grant(2, 0, 1'b0, 1'b0, 32'h0, "pre_rst0");
        tick();
        req[2] = '0;
        set_req(2, 1, 1'b0, SZ_WORD, 32'h4, 32'h0);
        expect_grant(2, 1, 1'b0, 1'b0, 32'h0, "pre_rst1");
        tick();
        rst[2] = 1'b1;
        for (int m = 0; m < 4; m++) set_req(2, m, 1'b0, SZ_WORD, 32'h60 + 32'(4 * m), 32'h0);
        @(negedge clk);
        check("midrst_data_ok", data_ok[2], 0);
        check("midrst_addr_ok", addr_ok[2], 0);
        check("midrst_mem_en", mem_en_o[2], 0);
        tick();
        rst[2] = 1'b0;
        expect_grant(2, 0, 1'b1, 1'b1, ram_init(2, 24), "post_rst0");
        tick();
        expect_grant(2, 1, 1'b1, 1'b1, ram_init(2, 25), "post_rst1");
        tick();
        req[2] = '0;

        repeat (8) tick();
        check("q0_drained", exp_q0.size(), 0);
        check("q1_drained", exp_q1.size(), 0);
        check("q2_drained", exp_q2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
